audio_clock_generator: RTL and testbench
========================================

// Module: audio_clock_generator
// PURPOSE
//  Master-mode I2S clock source: derives bit clock (bclk) and left/right clock (lrclk) from clk and
//  emits one-cycle edge strobes aligned to those clocks. Transmit-side counterpart of the edge
//  detector that recovers edges from an external audio clock. Feeds codec pins and local serializers.
//  Start/stop only at frame boundaries, so no truncated samples.
// PARAMETERS
//  BCLK_HALF_PERIOD  16  clk cycles per bclk half period (>=1)
//  BITS_PER_CHANNEL  32  bclk periods per lrclk half period (>=1)
//  MCLK_HALF_PERIOD  2   clk cycles per mclk half period (>=1); used only with macro
// PORTS
//  clk                input   1  system clock
//  reset              input   1  synchronous, active-high
//  enable             input   1  request clocks running; level-sensitive
//  bclk               output  1  generated bit clock
//  lrclk              output  1  generated word clock; 0 = left, 1 = right
//  bclk_rising_edge   output  1  high the single cycle bclk first reads 1
//  bclk_falling_edge  output  1  high the single cycle bclk first reads 0
//  lrclk_rising_edge  output  1  high the single cycle lrclk first reads 1
//  lrclk_falling_edge output  1  high the single cycle lrclk first reads 0
//  running            output  1  high in RUN or STOPPING
//  mclk               output  1  master clock; tied 0 without macro
// BEHAVIOUR
//  - All outputs registered. Reset (any cycle, mid-frame included): state IDLE, counters 0, every output 0 next cycle.
//  - FSM: IDLE -> RUN when enable sampled 1; RUN -> STOPPING when enable sampled 0;
//    STOPPING -> RUN when enable sampled 1 (no discontinuity, counters untouched);
//    STOPPING -> IDLE on the edge where lrclk falls (end of right channel).
//  - IDLE: bclk=lrclk=0, div_cnt=bit_cnt=0, no strobes, running=0.
//  - div_cnt counts 0..BCLK_HALF_PERIOD-1 in RUN/STOPPING; at terminal count wraps to 0, bclk toggles.
//  - If enable sampled 1 at edge N: bclk rises at edge N+BCLK_HALF_PERIOD, period 2*BCLK_HALF_PERIOD.
//  - bit_cnt increments on each bclk falling toggle; at BITS_PER_CHANNEL-1 wraps to 0 and lrclk
//    toggles on that same edge (lrclk changes with bclk falling, I2S alignment).
//  - Strobes: same-cycle as new level; lrclk strobes always coincide with bclk_falling_edge.
//  - Never two bclk strobes in one cycle; BCLK_HALF_PERIOD=1 gives bclk = clk/2, strobes alternate.
//  - Frame = 2*BITS_PER_CHANNEL bclk periods; STOPPING always completes current frame incl. final
//    lrclk falling strobe, then IDLE with bclk=0 (last bclk toggle was the falling one).
//  - enable toggling inside one frame while STOPPING/RUN: only frame-end decision uses its value.
// CONFIGURATION
//  - Macro AUDIO_CLK_GEN_MCLK_EN defined: mclk toggles every MCLK_HALF_PERIOD clk cycles while
//    running=1, own counter, held 0 and counter cleared in IDLE/reset.
//  - Undefined: no mclk counter synthesized, mclk constant 0; all other behaviour identical.
// STRUCTURE
//  - Package audio_clk_pkg: state enum {IDLE, RUN, STOPPING}; cnt_width function (clog2, min 1).
//  - Sub-module audio_clk_divider (param HALF_PERIOD; in clk, reset, run; out tick one cycle at
//    terminal count): instantiated for bclk divider and, under macro, for mclk.
//  - Top holds FSM, bit_cnt, output/strobe registers.
// TESTING (BCLK_HALF_PERIOD=2, BITS_PER_CHANNEL=4 unless noted)
//  - reset=1, enable=1 for 10 cycles -> all outputs 0, no strobes, running=0.
//  - enable=1 sampled at edge N -> bclk rise+strobe at N+2, fall at N+4, lrclk rise+strobe at N+16,
//    lrclk fall at N+32, pattern repeats every 32 cycles.
//  - enable=0 at N+6 -> clocks continue, lrclk falls at N+32, IDLE after, running=0, no strobes.
//  - enable=0 at N+6, enable=1 at N+20 -> waveform identical to uninterrupted run, running stays 1.
//  - reset pulse at N+11 -> next cycle all outputs 0; restart from IDLE matches scenario 2.
//  - Macro defined, MCLK_HALF_PERIOD=1 -> mclk toggles every cycle while running, 0 in IDLE;
//    macro undefined -> mclk stays 0 throughout.

Source files
------------

// File: rtl/audio_clk_pkg.sv
// Shared types and helpers for the I2S master clock generator.
package audio_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_clk_divider.sv
// Free-running divider: counts 0..HALF_PERIOD-1 while run is high and pulses tick at terminal count.
module audio_clk_divider
  import audio_clk_pkg::*;
#(
  parameter int HALF_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int W = cnt_width(HALF_PERIOD);
  localparam logic [W-1:0] TERM = W'(HALF_PERIOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick  = run && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_clock_generator.sv
// I2S master clock source: bclk/lrclk with edge strobes, starting and stopping on frame boundaries.
// Optional mclk output enabled by defining AUDIO_CLK_GEN_MCLK_EN.
module audio_clock_generator
  import audio_clk_pkg::*;
#(
  parameter int BCLK_HALF_PERIOD = 16,
  parameter int BITS_PER_CHANNEL = 32,
  parameter int MCLK_HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic lrclk,
  output logic bclk_rising_edge,
  output logic bclk_falling_edge,
  output logic lrclk_rising_edge,
  output logic lrclk_falling_edge,
  output logic running,
  output logic mclk
);

  localparam int BIT_W = cnt_width(BITS_PER_CHANNEL);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_CHANNEL - 1);

  // Periods below one clk cycle have no meaning; such configurations elaborate this marker block.
  if (BCLK_HALF_PERIOD < 1 || BITS_PER_CHANNEL < 1 || MCLK_HALF_PERIOD < 1) begin : g_invalid_params
  end

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             bclk_rise_q, bclk_rise_d;
  logic             bclk_fall_q, bclk_fall_d;
  logic             lrclk_rise_q, lrclk_rise_d;
  logic             lrclk_fall_q, lrclk_fall_d;
  logic             running_q, running_d;
  logic             active;
  logic             bclk_tick;
  logic             frame_end;

  assign active = (state_q != IDLE);

  audio_clk_divider #(
    .HALF_PERIOD(BCLK_HALF_PERIOD)
  ) u_bclk_div (
    .clk  (clk),
    .reset(reset),
    .run  (active),
    .tick (bclk_tick)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bclk_d       = bclk_q;
    lrclk_d      = lrclk_q;
    bclk_rise_d  = 1'b0;
    bclk_fall_d  = 1'b0;
    lrclk_rise_d = 1'b0;
    lrclk_fall_d = 1'b0;
    // Frame ends on the bclk fall that closes the last bit of the right channel.
    frame_end    = bclk_tick && bclk_q && lrclk_q && (bit_cnt_q == LAST_BIT);

    if (bclk_tick) begin
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        bclk_fall_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d    = '0;
          lrclk_d      = ~lrclk_q;
          lrclk_rise_d = ~lrclk_q;
          lrclk_fall_d = lrclk_q;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end else begin
        bclk_rise_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: begin
        if (enable) begin
          state_d = RUN;
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      bclk_rise_q  <= 1'b0;
      bclk_fall_q  <= 1'b0;
      lrclk_rise_q <= 1'b0;
      lrclk_fall_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      bclk_rise_q  <= bclk_rise_d;
      bclk_fall_q  <= bclk_fall_d;
      lrclk_rise_q <= lrclk_rise_d;
      lrclk_fall_q <= lrclk_fall_d;
      running_q    <= running_d;
    end
  end

  assign bclk               = bclk_q;
  assign lrclk              = lrclk_q;
  assign bclk_rising_edge   = bclk_rise_q;
  assign bclk_falling_edge  = bclk_fall_q;
  assign lrclk_rising_edge  = lrclk_rise_q;
  assign lrclk_falling_edge = lrclk_fall_q;
  assign running            = running_q;

`ifdef AUDIO_CLK_GEN_MCLK_EN
  logic mclk_tick;
  logic mclk_q, mclk_d;

  audio_clk_divider #(
    .HALF_PERIOD(MCLK_HALF_PERIOD)
  ) u_mclk_div (
    .clk  (clk),
    .reset(reset),
    .run  (running_q),
    .tick (mclk_tick)
  );

  always_comb begin
    mclk_d = mclk_q;
    if (!running_d) begin
      mclk_d = 1'b0;
    end else if (mclk_tick) begin
      mclk_d = ~mclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_q <= 1'b0;
    end else begin
      mclk_q <= mclk_d;
    end
  end

  assign mclk = mclk_q;
`else
  assign mclk = 1'b0;
`endif

endmodule

// File: tb/tb_audio_clock_generator.sv
// Randomized and directed bench for audio_clock_generator against a phase-arithmetic reference model.
module tb_audio_clock_generator;

  localparam int H = 2;
  localparam int B = 4;
  localparam int M = 1;
  localparam int FRAME = 4 * H * B;

  logic clk;
  logic reset;
  logic enable;
  logic bclk;
  logic lrclk;
  logic bclk_rising_edge;
  logic bclk_falling_edge;
  logic lrclk_rising_edge;
  logic lrclk_falling_edge;
  logic running;
  logic mclk;

  int compared;
  int mismatched;
  int cyc;

  audio_clock_generator #(
    .BCLK_HALF_PERIOD(H),
    .BITS_PER_CHANNEL(B),
    .MCLK_HALF_PERIOD(M)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .bclk              (bclk),
    .lrclk             (lrclk),
    .bclk_rising_edge  (bclk_rising_edge),
    .bclk_falling_edge (bclk_falling_edge),
    .lrclk_rising_edge (lrclk_rising_edge),
    .lrclk_falling_edge(lrclk_falling_edge),
    .running           (running),
    .mclk              (mclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outputs follow from the number of clk cycles t since the clocks started.
  bit mActive;
  bit mStopping;
  bit started;
  int t;
  logic expBclk, expLrclk, expBre, expBfe, expLre, expLfe, expRunning, expMclk;

  task automatic clearExpected();
    expBclk    = 1'b0;
    expLrclk   = 1'b0;
    expBre     = 1'b0;
    expBfe     = 1'b0;
    expLre     = 1'b0;
    expLfe     = 1'b0;
    expRunning = 1'b0;
    expMclk    = 1'b0;
  endtask

  initial begin
    mActive   = 1'b0;
    mStopping = 1'b0;
    started   = 1'b0;
    t         = 0;
    cyc       = 0;
    clearExpected();
  end

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (reset) begin
      mActive = 1'b0;
      t = 0;
      clearExpected();
    end else if (!mActive) begin
      clearExpected();
      if (enable) begin
        mActive    = 1'b1;
        mStopping  = 1'b0;
        t          = 0;
        expRunning = 1'b1;
      end
    end else begin
      t++;
      expBclk  = ((t / H) % 2) == 1;
      expLrclk = ((t / (2 * H * B)) % 2) == 1;
      expBre   = expBclk && (((t - 1) / H) % 2) == 0;
      expBfe   = !expBclk && (((t - 1) / H) % 2) == 1;
      expLre   = expLrclk && (((t - 1) / (2 * H * B)) % 2) == 0;
      expLfe   = !expLrclk && (((t - 1) / (2 * H * B)) % 2) == 1;
      if ((t % FRAME) == 0 && mStopping && !enable) mActive = 1'b0;
      mStopping  = !enable;
      expRunning = mActive;
`ifdef AUDIO_CLK_GEN_MCLK_EN
      expMclk = mActive && (((t / M) % 2) == 1);
`else
      expMclk = 1'b0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("bclk", bclk, expBclk);
      checkOutput("lrclk", lrclk, expLrclk);
      checkOutput("bclk_rising_edge", bclk_rising_edge, expBre);
      checkOutput("bclk_falling_edge", bclk_falling_edge, expBfe);
      checkOutput("lrclk_rising_edge", lrclk_rising_edge, expLre);
      checkOutput("lrclk_falling_edge", lrclk_falling_edge, expLfe);
      checkOutput("running", running, expRunning);
      checkOutput("mclk", mclk, expMclk);
    end
  end

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
  endtask

  // Starts clocks from IDLE so that edge N samples enable=1, then checks literal waveform points.
  task automatic runDirected(input int scen, input int stopAt, input int resumeAt, input int resetAt);
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    for (int j = 0; j <= 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      case (scen)
        0: begin
          if (j == 0) checkOutput("lit_start_running", running, 1'b1);
          if (j == 2) checkOutput("lit_first_bclk_rise", bclk_rising_edge, 1'b1);
          if (j == 4) checkOutput("lit_first_bclk_fall", bclk_falling_edge, 1'b1);
          if (j == 16) begin
            checkOutput("lit_first_lrclk_rise", lrclk_rising_edge, 1'b1);
            checkOutput("lit_lrclk_rise_bclk_fall", bclk_falling_edge, 1'b1);
          end
          if (j == 32) checkOutput("lit_first_lrclk_fall", lrclk_falling_edge, 1'b1);
          if (j == 34) checkOutput("lit_second_frame_bclk_rise", bclk_rising_edge, 1'b1);
        end
        1: begin
          if (j == 31) checkOutput("lit_stop_still_running", running, 1'b1);
          if (j == 32) begin
            checkOutput("lit_stop_final_lrclk_fall", lrclk_falling_edge, 1'b1);
            checkOutput("lit_stop_running_low", running, 1'b0);
          end
          if (j == 34) checkOutput("lit_stop_no_bclk_rise", bclk_rising_edge, 1'b0);
          if (j == 36) checkOutput("lit_stop_bclk_idle", bclk, 1'b0);
        end
        2: begin
          if (j == 32) checkOutput("lit_resume_running", running, 1'b1);
          if (j == 34) checkOutput("lit_resume_bclk_rise", bclk_rising_edge, 1'b1);
        end
        3: begin
          if (j == 11) begin
            checkOutput("lit_reset_running", running, 1'b0);
            checkOutput("lit_reset_bclk", bclk, 1'b0);
          end
          if (j == 14) checkOutput("lit_restart_bclk_rise", bclk_rising_edge, 1'b1);
        end
        default: ;
      endcase
      applyStimulus(j + 1 == resetAt, (j + 1 == stopAt) ? 1'b0 : (j + 1 == resumeAt) ? 1'b1 : enable);
    end
  endtask

  initial begin
    logic rst;
    logic en;
    compared   = 0;
    mismatched = 0;
    applyStimulus(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("lit_reset_running", running, 1'b0);
    checkOutput("lit_reset_bclk_strobe", bclk_rising_edge, 1'b0);

    runDirected(0, -1, -1, -1);
    runDirected(1, 6, -1, -1);
    runDirected(2, 6, 20, -1);
    runDirected(3, -1, -1, 11);

    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 3) en = ~en;
      applyStimulus(rst, en);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0);
    repeat (2 * FRAME + 4) @(negedge clk);
    checkOutput("lit_final_idle_running", running, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
